regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback_pkg.sv | 29 ++
 rtl/regfile_writeback_if.sv | 46 ++++
 rtl/regfile_writeback_fifo.sv | 56 +++++
 rtl/regfile_writeback.sv | 108 ++++++++++
 tb/tb_regfile_writeback.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared RISC-V types for the writeback slice.
//   XLEN / REG_ADDR_W : datapath and register-address widths
//   wb_entry_t        : one pending register-file write {rd, data}
//   wb_src_e          : which source won arbitration this cycle
//   writes_reg()      : false for x0, whose writes are dropped
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t rd;
    xlen_t     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_ALU  = 2'd2
  } wb_src_e;

  function automatic logic writes_reg(input reg_addr_t rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle of the writeback block's handshake, register-file write port and
// forwarding signals.
//   master : producer side (drives alu_*/mem_* requests, wr_stall, fwd_addr*)
//   slave  : regfile_writeback side
interface regfile_writeback_if;
  import riscv_pkg::*;

  logic      alu_valid;
  reg_addr_t alu_rd;
  xlen_t     alu_data;
  logic      alu_ready;

  logic      mem_valid;
  reg_addr_t mem_rd;
  xlen_t     mem_data;
  logic      mem_ready;

  logic      wr_stall;
  logic      wr_en;
  reg_addr_t wr_addr;
  xlen_t     wr_data;

  reg_addr_t fwd_addr1;
  reg_addr_t fwd_addr2;
  logic      fwd_hit1;
  logic      fwd_hit2;
  xlen_t     fwd_data1;
  xlen_t     fwd_data2;

  logic      busy;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           wr_stall, fwd_addr1, fwd_addr2,
    input  alu_ready, mem_ready, wr_en, wr_addr, wr_data,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           wr_stall, fwd_addr1, fwd_addr2,
    output alu_ready, mem_ready, wr_en, wr_addr, wr_data,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, busy
  );

endinterface

// File: rtl/regfile_writeback_fifo.sv
// wb_fifo: in-order queue of pending register-file writes.
//   clk, reset : clock, asynchronous active-high reset (empties the queue)
//   push       : enqueue push_entry (caller guarantees not full)
//   pop        : drop the head (caller guarantees not empty)
//   entries    : queue contents in age order, entries[0] = head (oldest)
//   count      : number of valid entries, 0..DEPTH
module wb_fifo
  import riscv_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        entries [DEPTH],
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage needs no reset: count gates every use of it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Rotate so consumers see age order without knowing the pointers.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      entries[k] = mem[rd_ptr + PTR_W'(k)];
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU and load results into a single register-file
// write port through a DEPTH-entry in-order queue, with optional bypass of
// pending writes to readers.
//   clk   : sole clock, rising edge
//   reset : asynchronous active-high; empties the queue at once
//   wb    : regfile_writeback_if.slave
//           alu_* / mem_* valid-ready sources (mem has priority),
//           wr_stall / wr_en / wr_addr / wr_data register-file write port,
//           fwd_addr* / fwd_hit* / fwd_data* bypass, busy = queue non-empty
// Build option: define REGFILE_WB_FORWARD_EN to build the bypass logic;
// otherwise fwd_hit*/fwd_data* are tied to 0.
module regfile_writeback
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  regfile_writeback_if.slave wb
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        entries [DEPTH];
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  wb_src_e          src;
  wb_entry_t        push_entry;
  logic             push;
  logic             pop;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .entries    (entries),
    .count      (count)
  );

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // Ready comes from the pre-pop count, so a full queue refuses input even
  // on the edge where it drains one entry.
  assign wb.mem_ready = !reset && !full;
  assign wb.alu_ready = !reset && !full && !wb.mem_valid;

  always_comb begin
    src        = SRC_NONE;
    push_entry = '0;
    if (wb.mem_valid && wb.mem_ready) begin
      src        = SRC_MEM;
      push_entry = '{rd: wb.mem_rd, data: wb.mem_data};
    end else if (wb.alu_valid && wb.alu_ready) begin
      src        = SRC_ALU;
      push_entry = '{rd: wb.alu_rd, data: wb.alu_data};
    end
  end

  // x0 transfers complete the handshake but are never queued.
  assign push = (src != SRC_NONE) && writes_reg(push_entry.rd);
  assign pop  = !empty && !wb.wr_stall;

  always_comb begin
    wb.wr_en   = pop;
    wb.wr_addr = '0;
    wb.wr_data = '0;
    if (pop) begin
      wb.wr_addr = entries[0].rd;
      wb.wr_data = entries[0].data;
    end
  end

  assign wb.busy = !empty;

`ifdef REGFILE_WB_FORWARD_EN
  // Scan oldest to youngest; later matches overwrite, leaving the youngest.
  always_comb begin
    wb.fwd_hit1  = 1'b0;
    wb.fwd_hit2  = 1'b0;
    wb.fwd_data1 = '0;
    wb.fwd_data2 = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count) begin
        if (writes_reg(wb.fwd_addr1) && entries[k].rd == wb.fwd_addr1) begin
          wb.fwd_hit1  = 1'b1;
          wb.fwd_data1 = entries[k].data;
        end
        if (writes_reg(wb.fwd_addr2) && entries[k].rd == wb.fwd_addr2) begin
          wb.fwd_hit2  = 1'b1;
          wb.fwd_data2 = entries[k].data;
        end
      end
    end
  end
`else
  assign wb.fwd_hit1  = 1'b0;
  assign wb.fwd_hit2  = 1'b0;
  assign wb.fwd_data1 = '0;
  assign wb.fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback (DEPTH = 4). A table of per-cycle
// {inputs, expected outputs} rows drives one continuous scenario from reset;
// hand-written sequences cover reset state and a mid-operation reset.
// Forwarding expectations apply when REGFILE_WB_FORWARD_EN is defined,
// otherwise fwd_* are expected to be 0.
module tb_regfile_writeback;

`ifdef REGFILE_WB_FORWARD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] adat;
    logic        mv;  logic [4:0] mrd; logic [31:0] mdat;
    logic        st;  logic [4:0] f1;  logic [4:0]  f2;
    logic        ar;  logic       mr;
    logic        we;  logic [4:0] wa;  logic [31:0] wd;
    logic        bz;
    logic        h1;  logic [31:0] d1; logic h2; logic [31:0] d2;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl [28];

  always #5 clk = ~clk;

  regfile_writeback_if bus ();

  regfile_writeback #(
    .DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.alu_valid = v.av;  bus.alu_rd = v.ard; bus.alu_data = v.adat;
    bus.mem_valid = v.mv;  bus.mem_rd = v.mrd; bus.mem_data = v.mdat;
    bus.wr_stall  = v.st;  bus.fwd_addr1 = v.f1; bus.fwd_addr2 = v.f2;
  endtask

  task automatic check_row(input string tag, input vec_t v);
    n_vec++;
    chk({tag, " alu_ready"}, 32'(bus.alu_ready), 32'(v.ar));
    chk({tag, " mem_ready"}, 32'(bus.mem_ready), 32'(v.mr));
    chk({tag, " wr_en"},     32'(bus.wr_en),     32'(v.we));
    chk({tag, " wr_addr"},   32'(bus.wr_addr),   32'(v.wa));
    chk({tag, " wr_data"},   bus.wr_data,        v.wd);
    chk({tag, " busy"},      32'(bus.busy),      32'(v.bz));
    chk({tag, " fwd_hit1"},  32'(bus.fwd_hit1),  32'(v.h1 & FWD));
    chk({tag, " fwd_data1"}, bus.fwd_data1,      v.d1 & {32{FWD}});
    chk({tag, " fwd_hit2"},  32'(bus.fwd_hit2),  32'(v.h2 & FWD));
    chk({tag, " fwd_data2"}, bus.fwd_data2,      v.d2 & {32{FWD}});
  endtask

  initial begin
    vec_t idle;
    vec_t v;

    //              av ard adat          mv mrd mdat    st f1 f2  ar mr  we wa wd            bz  h1 d1     h2 d2
    // x1 write, one-cycle latency
    tbl[0]  = '{N, 5'd0, 32'h0,        N, 5'd0, 32'h0,  N, 5'd0, 5'd0, Y, Y, N, 5'd0, 32'h0,        N, N, 32'h0, N, 32'h0};
    tbl[1]  = '{Y, 5'd1, 32'hBEEFDEAD, N, 5'd0, 32'h0,  N, 5'd0, 5'd0, Y, Y, N, 5'd0, 32'h0,        N, N, 32'h0, N, 32'h0};
    tbl[2]  = '{N, 5'd0, 32'h0,        N, 5'd0, 32'h0,  N, 5'd0, 5'd0, Y, Y, Y, 5'd1, 32'hBEEFDEAD, Y, N, 32'h0, N, 32'h0};
    tbl[3]  = '{N, 5'd0, 32'h0,        N, 5'd0, 32'h0,  N, 5'd0, 5'd0, Y, Y, N, 5'd0, 32'h0,        N, N, 32'h0, N, 32'h0};
    // x0 write accepted but dropped
    tbl[4]  = '{Y, 5'd0, 32'hDEADBEEF, N, 5'd0, 32'h0,  N, 5'd0, 5'd0, Y, Y, N, 5'd0, 32'h0,        N, N, 32'h0, N, 32'h0};
    tbl[5]  = '{N, 5'd0, 32'h0,        N, 5'd0, 32'h0,  N, 5'd0, 5'd0, Y, Y, N, 5'd0, 32'h0,        N, N, 32'h0, N, 32'h0};
    // mem beats alu
    tbl[6]  = '{Y, 5'd2, 32'h11,       Y, 5'd3, 32'h22, N, 5'd0, 5'd0, N, Y, N, 5'd0, 32'h0,        N, N, 32'h0, N, 32'h0};
    tbl[7]  = '{Y, 5'd2, 32'h11,       N, 5'd0, 32'h0,  N, 5'd0, 5'd0, Y, Y, Y, 5'd3, 32'h22,       Y, N, 32'h0, N, 32'h0};
    tbl[8]  = '{N, 5'd0, 32'h0,        N, 5'd0, 32'h0,  N, 5'd0, 5'd0, Y, Y, Y, 5'd2, 32'h11,       Y, N, 32'h0, N, 32'h0};
    tbl[9]  = '{N, 5'd0, 32'h0,        N, 5'd0, 32'h0,  N, 5'd0, 5'd0, Y, Y, N, 5'd0, 32'h0,        N, N, 32'h0, N, 32'h0};
    // fill under stall, full, push+pop at full, drain in order
    tbl[10] = '{N, 5'd0, 32'h0,        Y, 5'd4, 32'h44, Y, 5'd0, 5'd0, N, Y, N, 5'd0, 32'h0,        N, N, 32'h0, N, 32'h0};
    tbl[11] = '{N, 5'd0, 32'h0,        Y, 5'd5, 32'h55, Y, 5'd0, 5'd0, N, Y, N, 5'd0, 32'h0,        Y, N, 32'h0, N, 32'h0};
    tbl[12] = '{N, 5'd0, 32'h0,        Y, 5'd6, 32'h66, Y, 5'd0, 5'd0, N, Y, N, 5'd0, 32'h0,        Y, N, 32'h0, N, 32'h0};
    tbl[13] = '{N, 5'd0, 32'h0,        Y, 5'd7, 32'h77, Y, 5'd0, 5'd0, N, Y, N, 5'd0, 32'h0,        Y, N, 32'h0, N, 32'h0};
    tbl[14] = '{N, 5'd0, 32'h0,        Y, 5'd8, 32'h88, Y, 5'd5, 5'd9, N, N, N, 5'd0, 32'h0,        Y, Y, 32'h55, N, 32'h0};
    tbl[15] = '{N, 5'd0, 32'h0,        Y, 5'd8, 32'h88, N, 5'd0, 5'd0, N, N, Y, 5'd4, 32'h44,       Y, N, 32'h0, N, 32'h0};
    tbl[16] = '{N, 5'd0, 32'h0,        Y, 5'd8, 32'h88, N, 5'd0, 5'd0, N, Y, Y, 5'd5, 32'h55,       Y, N, 32'h0, N, 32'h0};
    tbl[17] = '{N, 5'd0, 32'h0,        N, 5'd0, 32'h0,  N, 5'd0, 5'd0, Y, Y, Y, 5'd6, 32'h66,       Y, N, 32'h0, N, 32'h0};
    tbl[18] = '{N, 5'd0, 32'h0,        N, 5'd0, 32'h0,  N, 5'd0, 5'd0, Y, Y, Y, 5'd7, 32'h77,       Y, N, 32'h0, N, 32'h0};
    tbl[19] = '{N, 5'd0, 32'h0,        N, 5'd0, 32'h0,  N, 5'd0, 5'd0, Y, Y, Y, 5'd8, 32'h88,       Y, N, 32'h0, N, 32'h0};
    tbl[20] = '{N, 5'd0, 32'h0,        N, 5'd0, 32'h0,  N, 5'd0, 5'd0, Y, Y, N, 5'd0, 32'h0,        N, N, 32'h0, N, 32'h0};
    // forwarding picks the youngest x5
    tbl[21] = '{Y, 5'd5, 32'hA,        N, 5'd0, 32'h0,  Y, 5'd5, 5'd0, Y, Y, N, 5'd0, 32'h0,        N, N, 32'h0, N, 32'h0};
    tbl[22] = '{Y, 5'd5, 32'hB,        N, 5'd0, 32'h0,  Y, 5'd5, 5'd0, Y, Y, N, 5'd0, 32'h0,        Y, Y, 32'hA, N, 32'h0};
    tbl[23] = '{N, 5'd0, 32'h0,        N, 5'd0, 32'h0,  Y, 5'd5, 5'd0, Y, Y, N, 5'd0, 32'h0,        Y, Y, 32'hB, N, 32'h0};
    tbl[24] = '{N, 5'd0, 32'h0,        N, 5'd0, 32'h0,  Y, 5'd6, 5'd5, Y, Y, N, 5'd0, 32'h0,        Y, N, 32'h0, Y, 32'hB};
    tbl[25] = '{N, 5'd0, 32'h0,        N, 5'd0, 32'h0,  N, 5'd5, 5'd0, Y, Y, Y, 5'd5, 32'hA,        Y, Y, 32'hB, N, 32'h0};
    tbl[26] = '{N, 5'd0, 32'h0,        N, 5'd0, 32'h0,  N, 5'd5, 5'd0, Y, Y, Y, 5'd5, 32'hB,        Y, Y, 32'hB, N, 32'h0};
    tbl[27] = '{N, 5'd0, 32'h0,        N, 5'd0, 32'h0,  N, 5'd5, 5'd0, Y, Y, N, 5'd0, 32'h0,        N, N, 32'h0, N, 32'h0};

    idle = tbl[0];
    drive(idle);

    // Reset state: readies also held low while reset is high.
    @(negedge clk);
    #2;
    v = idle;
    v.ar = N; v.mr = N;
    check_row("reset", v);
    reset = 1'b0;

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #2;
      check_row($sformatf("row%0d", i), tbl[i]);
    end

    // Mid-operation reset with three entries queued under stall.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v = idle;
      v.mv = Y; v.mrd = 5'(10 + i); v.mdat = 32'hA1 + 32'(i); v.st = Y; v.f1 = 5'd10;
      drive(v);
    end
    @(negedge clk);
    v = idle;
    v.st = Y; v.f1 = 5'd10;
    drive(v);
    #2;
    v.bz = Y; v.h1 = Y; v.d1 = 32'hA1;
    check_row("prefill", v);
    #1 reset = 1'b1;
    #1;
    v = idle;
    v.st = Y; v.f1 = 5'd10; v.ar = N; v.mr = N;
    check_row("rst_now", v);
    bus.wr_stall = 1'b0;
    #1;
    v.st = N;
    check_row("rst_unstall", v);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2;
      v = idle;
      v.f1 = 5'd10;
      check_row($sformatf("post_rst%0d", i), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
